// File: rtl/sram_cmd_ctrl.sv
// Command sequencer for the SRAM macro: turns single-word bus requests into
// SIPO shift / write-enable / read-enable pin sequences, one request at a time.
module sram_cmd_ctrl #(
  parameter int ROWS    = 16,
  parameter int COLS    = 8,
  parameter int AW      = $clog2(ROWS),
  parameter int WR_HOLD = 2,
  parameter int RD_WAIT = 2
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [COLS-1:0] rsp_rdata,
  output logic            sram_serial_in,
  output logic            sram_shift,
  output logic            sram_w_en,
  output logic            sram_r_en,
  output logic [ROWS-1:0] sram_addr,
  input  logic            sram_data_valid,
  input  logic [COLS-1:0] sram_data_out
);

  localparam int MAX_A   = (COLS > WR_HOLD) ? COLS : WR_HOLD;
  localparam int MAX_CNT = (MAX_A > RD_WAIT) ? MAX_A : RD_WAIT;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] SHIFT_LAST = CW'(COLS - 1);
  localparam logic [CW-1:0] WRITE_LAST = CW'(WR_HOLD - 1);
  localparam logic [CW-1:0] READ_LAST  = CW'(RD_WAIT - 1);
  localparam logic [AW:0]   ROW_LIMIT  = (AW + 1)'(ROWS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_WRITE,
    S_READ,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [COLS-1:0] word_q, word_d;
  logic            err_q, err_d;
  logic [COLS-1:0] rdata_q, rdata_d;

  logic            shift_q, shift_d;
  logic            serial_q, serial_d;
  logic            w_en_q, w_en_d;
  logic            r_en_q, r_en_d;
  logic [ROWS-1:0] sram_addr_q, sram_addr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;

  logic addr_oob;
  assign addr_oob = ({1'b0, req_addr} >= ROW_LIMIT);

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    word_d  = word_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          word_d = req_wdata;
          cnt_d  = '0;
          err_d  = addr_oob;
          if (addr_oob)    state_d = S_RESP;
          else if (req_we) state_d = S_SHIFT;
          else             state_d = S_READ;
        end
      end
      S_SHIFT: begin
        // word_q always holds the not-yet-sent bits, MSB first
        word_d = word_q << 1;
        if (cnt_q == SHIFT_LAST) begin
          state_d = S_WRITE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE: begin
        if (cnt_q == WRITE_LAST) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_READ: begin
        // Counter parks on the last wait cycle and retries until the macro flags valid data.
        if (cnt_q == READ_LAST) begin
          if (sram_data_valid) begin
            rdata_d = sram_data_out;
            state_d = S_RESP;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pin values are decoded from the next state and registered, so they never glitch.
    shift_d     = (state_d == S_SHIFT);
    serial_d    = shift_d & word_d[COLS-1];
    w_en_d      = (state_d == S_WRITE);
    r_en_d      = (state_d == S_READ);
    sram_addr_d = (shift_d | w_en_d | r_en_d) ? ROWS'(addr_d) : '0;
    rsp_valid_d = (state_d == S_RESP);
    rsp_err_d   = rsp_valid_d & err_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      word_q      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      shift_q     <= 1'b0;
      serial_q    <= 1'b0;
      w_en_q      <= 1'b0;
      r_en_q      <= 1'b0;
      sram_addr_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      shift_q     <= shift_d;
      serial_q    <= serial_d;
      w_en_q      <= w_en_d;
      r_en_q      <= r_en_d;
      sram_addr_q <= sram_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_rdata      = rdata_q;
  assign sram_serial_in = serial_q;
  assign sram_shift     = shift_q;
  assign sram_w_en      = w_en_q;
  assign sram_r_en      = r_en_q;
  assign sram_addr      = sram_addr_q;

endmodule

// File: tb/tb_sram_cmd_ctrl.sv
// Directed bench for sram_cmd_ctrl: a behavioural SIPO/array model behind the
// pins, and a queue of expected responses checked when rsp_valid pulses.
module tb_sram_cmd_ctrl;

  localparam int ROWS    = 16;
  localparam int COLS    = 8;
  localparam int AW      = 4;
  localparam int WR_HOLD = 2;
  localparam int RD_WAIT = 2;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  logic            req_valid, req_ready, req_we;
  logic [AW-1:0]   req_addr;
  logic [COLS-1:0] req_wdata;
  logic            rsp_valid, rsp_err;
  logic [COLS-1:0] rsp_rdata;
  logic            sram_serial_in, sram_shift, sram_w_en, sram_r_en;
  logic [ROWS-1:0] sram_addr;
  logic            sram_data_valid;
  logic [COLS-1:0] sram_data_out;

  sram_cmd_ctrl #(.ROWS(ROWS), .COLS(COLS), .AW(AW), .WR_HOLD(WR_HOLD), .RD_WAIT(RD_WAIT)) u_dut (
    .clk(clk), .arst(arst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .sram_serial_in(sram_serial_in), .sram_shift(sram_shift),
    .sram_w_en(sram_w_en), .sram_r_en(sram_r_en), .sram_addr(sram_addr),
    .sram_data_valid(sram_data_valid), .sram_data_out(sram_data_out)
  );

  // Second instance with a non-power-of-two row count for the out-of-range path.
  logic            req_valid12, req_ready12, rsp_valid12, rsp_err12;
  logic [COLS-1:0] rsp_rdata12;
  logic            serial12, shift12, w_en12, r_en12;
  logic [11:0]     addr12;
  logic            dv12;
  logic [COLS-1:0] dout12;
  assign dv12   = 1'b0;
  assign dout12 = '0;

  sram_cmd_ctrl #(.ROWS(12), .COLS(COLS), .AW(AW), .WR_HOLD(WR_HOLD), .RD_WAIT(RD_WAIT)) u_dut12 (
    .clk(clk), .arst(arst),
    .req_valid(req_valid12), .req_ready(req_ready12), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid12), .rsp_err(rsp_err12), .rsp_rdata(rsp_rdata12),
    .sram_serial_in(serial12), .sram_shift(shift12),
    .sram_w_en(w_en12), .sram_r_en(r_en12), .sram_addr(addr12),
    .sram_data_valid(dv12), .sram_data_out(dout12)
  );

  // Macro model: SIPO shifts MSB first, w_en copies SIPO into the row, reads
  // become valid after RD_WAIT + dv_delay r_en cycles; junk is driven until then.
  logic [COLS-1:0] sipo = '0;
  logic [COLS-1:0] mem [ROWS];
  int rcnt     = 0;
  int dv_delay = 0;

  always @(posedge clk) begin
    if (sram_shift) sipo <= {sipo[COLS-2:0], sram_serial_in};
    if (sram_w_en)  mem[sram_addr[AW-1:0]] <= sipo;
    rcnt <= sram_r_en ? rcnt + 1 : 0;
  end
  assign sram_data_valid = sram_r_en && (rcnt >= RD_WAIT - 1 + dv_delay);
  assign sram_data_out   = sram_data_valid ? mem[sram_addr[AW-1:0]] : 8'h5A;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pin-level properties checked every cycle.
  int bad12 = 0;
  always @(negedge clk) begin
    check("enables_exclusive", 32'($countones({sram_shift, sram_w_en, sram_r_en}) > 1), 0);
    if (shift12 || w_en12 || r_en12 || addr12 != '0) bad12++;
  end

  typedef struct {
    logic            err;
    logic [COLS-1:0] rdata;
    int              lat;
  } exp_t;

  exp_t            sb[$];
  logic [COLS-1:0] ref_mem [ROWS];
  logic [COLS-1:0] last_rdata = '0;

  function automatic exp_t expect_for(input logic we, input logic [AW-1:0] addr,
                                      input logic [COLS-1:0] wdata, input int extra);
    exp_t e;
    e.err = 1'b0;
    if (we) begin
      ref_mem[addr] = wdata;
      e.rdata = last_rdata;
      e.lat   = COLS + WR_HOLD + 1;
    end else begin
      last_rdata = ref_mem[addr];
      e.rdata = last_rdata;
      e.lat   = RD_WAIT + 1 + extra;
    end
    return e;
  endfunction

  task automatic do_req(input logic we, input logic [AW-1:0] addr,
                        input logic [COLS-1:0] wdata, input int extra);
    exp_t e;
    int n = 0, nshift = 0, nwen = 0, nren = 0, nready = 0, nbad = 0;
    bit seen = 0;
    logic [COLS-1:0] bits = '0;
    check("ready_before_req", req_ready, 1);
    sb.push_back(expect_for(we, addr, wdata, extra));
    dv_delay  = extra;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (sram_shift) begin bits = {bits[COLS-2:0], sram_serial_in}; nshift++; end
      if (sram_w_en) nwen++;
      if (sram_r_en) nren++;
      if (req_ready) nready++;
      if ((sram_shift || sram_w_en || sram_r_en) ? (sram_addr !== ROWS'(addr)) : (sram_addr !== '0)) nbad++;
      if (rsp_valid) seen = 1;
    end
    check("rsp_seen", 32'(seen), 1);
    e = sb.pop_front();
    check("latency", n, e.lat);
    check("rsp_err", rsp_err, e.err);
    check("rsp_rdata", rsp_rdata, e.rdata);
    check("ready_low_busy", nready, 0);
    check("sram_addr_track", nbad, 0);
    if (we) begin
      check("shift_cycles", nshift, COLS);
      check("serial_bits", bits, wdata);
      check("wen_cycles", nwen, WR_HOLD);
      check("ren_in_write", nren, 0);
    end else begin
      check("ren_cycles", nren, e.lat - 1);
      check("shift_in_read", nshift + nwen, 0);
    end
    @(negedge clk);
    check("rsp_pulse_1cyc", rsp_valid, 0);
    check("ready_after", req_ready, 1);
    check("rdata_held", rsp_rdata, e.rdata);
  endtask

  initial begin
    int n, nready, nren, nev;
    exp_t e;
    req_valid = 0; req_valid12 = 0; req_we = 0; req_addr = '0; req_wdata = '0;

    // Reset values
    #1 arst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_err}, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_pins", {sram_serial_in, sram_shift, sram_w_en, sram_r_en}, 0);
    check("rst_addr", sram_addr, 0);
    arst = 1'b0;
    @(negedge clk);

    // Write / read, normal and delayed data_valid, top row
    do_req(1'b1, 4'd3, 8'hA5, 0);
    do_req(1'b0, 4'd3, 8'h00, 0);
    do_req(1'b0, 4'd3, 8'h00, 4);
    do_req(1'b1, 4'd15, 8'h81, 0);
    do_req(1'b0, 4'd15, 8'h00, 0);

    // Out-of-range request on the 12-row instance
    check("r12_ready", req_ready12, 1);
    req_valid12 = 1'b1; req_we = 1'b1; req_addr = 4'd13; req_wdata = 8'hFF;
    @(posedge clk);
    #1 req_valid12 = 1'b0;
    @(negedge clk);
    check("oob_rsp_valid", rsp_valid12, 1);
    check("oob_rsp_err", rsp_err12, 1);
    check("oob_ready_low", req_ready12, 0);
    @(negedge clk);
    check("oob_rsp_done", {rsp_valid12, rsp_err12}, 0);
    check("oob_ready_back", req_ready12, 1);
    check("oob_no_pin_activity", bad12, 0);

    // Reset during the 4th shift cycle of a write
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 8'h0F;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_in_shift", sram_shift, 1);
    #2 arst = 1'b1;
    #1;
    check("abort_pins_async", {sram_serial_in, sram_shift, sram_w_en, sram_r_en}, 0);
    check("abort_addr_async", sram_addr, 0);
    check("abort_rsp_async", {rsp_valid, rsp_err}, 0);
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    last_rdata = '0;
    check("abort_rdata_cleared", rsp_rdata, 0);
    check("abort_ready", req_ready, 1);
    nev = 0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid || sram_shift || sram_w_en || sram_r_en) nev++;
    end
    check("abort_no_activity", nev, 0);
    do_req(1'b0, 4'd3, 8'h00, 0);

    // Back-to-back write then read with req_valid held high
    sb.push_back(expect_for(1'b1, 4'd7, 8'hC3, 0));
    sb.push_back(expect_for(1'b0, 4'd7, 8'h00, 0));
    dv_delay  = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd7; req_wdata = 8'hC3;
    @(posedge clk);
    #1 req_we = 1'b0; req_wdata = 8'hFF;
    n = 0; nready = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (req_ready) nready++;
    end
    e = sb.pop_front();
    check("b2b_wr_latency", n, e.lat);
    check("b2b_wr_err", rsp_err, e.err);
    check("b2b_ready_low", nready, 0);
    @(negedge clk);
    check("b2b_first_idle_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0; nren = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (sram_r_en) nren++;
    end
    e = sb.pop_front();
    check("b2b_rd_latency", n, e.lat);
    check("b2b_rd_ren", nren, RD_WAIT);
    check("b2b_rd_rdata", rsp_rdata, e.rdata);
    @(negedge clk);
    check("b2b_idle", {rsp_valid, req_ready}, 2'b01);

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
